// File: rtl/branch_redirect.sv
// ---------------------------------------------------------------------------
// branch_redirect
//
// Takes a resolved branch from execute (integer compare or the float compare
// behind fbeq/fbne/fblt/fbge) and checks it against the fetch-time prediction.
// A correct prediction costs nothing: the unit stays IDLE and takes the next
// branch on the very next cycle. A mispredict offers the corrected PC to
// fetch, holds flush while that offer is pending, and keeps flush high for
// DRAIN_CYCLES more cycles after fetch takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid & ready are
// both 1. A valid source holds its payload stable until that edge. ready never
// depends on valid in the same cycle. ready seen while valid=0 is ignored.
//
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   br_valid/ready   branch handshake from execute (ready == state IDLE)
//   br_jump, br_pred resolved outcome and fetch prediction (1 = taken)
//   br_pc, br_target PC of the branch and its taken target
//   redirect_valid/ready, redirect_pc   corrected-PC handshake into fetch
//   flush            kill everything younger than the branch (registered)
//   busy             state != IDLE
//   state_dbg        raw FSM state (0 IDLE, 1 REDIRECT, 2 DRAIN)
//
// Optional feature, macro BRANCH_STATS_EN:
//   adds parameter CNT_W and outputs stat_branches / stat_mispred, counting
//   accepted branches and accepted mispredicts (wrap modulo 2^CNT_W).
// ---------------------------------------------------------------------------
module branch_redirect #(
  parameter int DRAIN_CYCLES = 2
`ifdef BRANCH_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic        br_jump,
  input  logic        br_pred,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_target,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        busy,
  output logic [1:0]  state_dbg
`ifdef BRANCH_STATS_EN
  , output logic [CNT_W-1:0] stat_branches
  , output logic [CNT_W-1:0] stat_mispred
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  // Counter only needs to hold DRAIN_CYCLES-1; keep at least one bit so the
  // DRAIN_CYCLES==0 and ==1 builds still elaborate.
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LOAD =
    (DRAIN_CYCLES > 0) ? DCW'(DRAIN_CYCLES - 1) : '0;

  state_t          state;
  logic [DCW-1:0]  drain_cnt;
  logic            accept;
  logic            mispredict;
  logic [31:0]     correct_pc;

  assign br_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;
  assign accept     = br_valid & br_ready;
  assign mispredict = br_jump ^ br_pred;
  // Fall-through address wraps naturally at 2^32.
  assign correct_pc = br_jump ? br_target : (br_pc + 32'd4);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      flush          <= 1'b0;
      drain_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && mispredict) begin
            state          <= REDIRECT;
            redirect_pc    <= correct_pc;
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
          end
        end
        REDIRECT: begin
          // redirect_pc is untouched here, so it stays stable until fetch
          // takes it.
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            if (DRAIN_CYCLES > 0) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end else begin
              state <= IDLE;
              flush <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush          <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else if (accept) begin
      stat_branches <= stat_branches + 1'b1;
      if (mispredict) begin
        stat_mispred <= stat_mispred + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// Directed bench for branch_redirect (default DRAIN_CYCLES = 2).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_branch_redirect;

  logic        clk;
  logic        rstn;
  logic        br_valid;
  logic        br_ready;
  logic        br_jump;
  logic        br_pred;
  logic [31:0] br_pc;
  logic [31:0] br_target;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        busy;
  logic [1:0]  state_dbg;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard: redirect PCs expected at fetch, in order.
  logic [31:0] exp_q[$];

  branch_redirect dut (
    .clk            (clk),
    .rstn           (rstn),
    .br_valid       (br_valid),
    .br_ready       (br_ready),
    .br_jump        (br_jump),
    .br_pred        (br_pred),
    .br_pc          (br_pc),
    .br_target      (br_target),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .busy           (busy),
    .state_dbg      (state_dbg)
`ifdef BRANCH_STATS_EN
    , .stat_branches (stat_branches)
    , .stat_mispred  (stat_mispred)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rstn           = 1'b0;
    br_valid       = 1'b0;
    br_jump        = 1'b0;
    br_pred        = 1'b0;
    br_pc          = 32'd0;
    br_target      = 32'd0;
    redirect_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- driver ----------------
  // Called on a falling edge; presents one branch for one cycle and returns
  // on the falling edge of the cycle after the accept edge.
  task automatic drive_branch(input logic jump, input logic pred,
                              input logic [31:0] pc, input logic [31:0] target);
    br_valid  = 1'b1;
    br_jump   = jump;
    br_pred   = pred;
    br_pc     = pc;
    br_target = target;
    @(negedge clk);
    br_valid  = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    br_valid = 1'b0;
    redirect_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({redirect_valid, flush, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs: rv/flush/busy=%b required 000", {redirect_valid, flush, busy});
    end
    n_checks++;
    if (redirect_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_pc: redirect_pc=%h required 00000000", redirect_pc);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (br_ready !== 1'b1 || state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_idle: br_ready=%b state=%0d required 1/0", br_ready, state_dbg);
    end
  endtask

  task automatic test_correct_pred();
    drive_branch(1'b1, 1'b1, 32'h100, 32'h200);
    n_checks++;
    if ({redirect_valid, flush, busy, br_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL correct_pred: rv/flush/busy/ready=%b required 0001",
               {redirect_valid, flush, busy, br_ready});
    end
  endtask

  task automatic test_mispredict_taken();
    int flush_cycles;
    redirect_ready = 1'b1;
    exp_q.push_back(32'h200);
    drive_branch(1'b1, 1'b0, 32'h100, 32'h200);
    n_checks++;
    if ({redirect_valid, flush, br_ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL mp_taken_first: rv/flush/ready=%b required 110",
               {redirect_valid, flush, br_ready});
    end
    n_checks++;
    if (redirect_pc !== exp_q[0]) begin
      n_fail++;
      $display("FAIL mp_taken_pc: redirect_pc=%h required %h", redirect_pc, exp_q[0]);
    end
    void'(exp_q.pop_front());
    flush_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!flush) break;
      flush_cycles++;
      n_checks++;
      if (redirect_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mp_taken_drain_rv: redirect_valid=%b required 0", redirect_valid);
      end
    end
    n_checks++;
    if (flush_cycles != 3) begin
      n_fail++;
      $display("FAIL mp_taken_flush_len: flush cycles=%0d required 3", flush_cycles);
    end
    n_checks++;
    if (br_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mp_taken_idle: br_ready=%b busy=%b required 1/0", br_ready, busy);
    end
    redirect_ready = 1'b0;
  endtask

  task automatic test_mispredict_wrap_stall();
    int flush_cycles;
    redirect_ready = 1'b0;
    exp_q.push_back(32'h0000_0000);
    drive_branch(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_1234);
    // A second (mispredicting) branch is offered while the first waits.
    br_valid  = 1'b1;
    br_jump   = 1'b1;
    br_pred   = 1'b0;
    br_pc     = 32'h0000_0800;
    br_target = 32'hDEAD_0000;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({redirect_valid, flush, br_ready} !== 3'b110 || redirect_pc !== exp_q[0]) begin
        n_fail++;
        $display("FAIL wrap_stall_hold[%0d]: rv/flush/ready=%b pc=%h required 110 pc=%h",
                 i, {redirect_valid, flush, br_ready}, redirect_pc, exp_q[0]);
      end
      if (i == 3) break;
      @(negedge clk);
    end
    // Fetch takes the redirect at the end of this (fourth) cycle.
    redirect_ready = 1'b1;
    br_valid = 1'b0;
    void'(exp_q.pop_front());
    flush_cycles = 4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!flush) break;
      flush_cycles++;
    end
    n_checks++;
    if (flush_cycles != 6) begin
      n_fail++;
      $display("FAIL wrap_stall_flush_len: flush cycles=%0d required 6", flush_cycles);
    end
    @(negedge clk);
    n_checks++;
    if ({redirect_valid, flush, busy, br_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_stall_no_second: rv/flush/busy/ready=%b required 0001",
               {redirect_valid, flush, busy, br_ready});
    end
    redirect_ready = 1'b0;
  endtask

  task automatic test_reset_in_drain();
    redirect_ready = 1'b1;
    exp_q.push_back(32'h400);
    drive_branch(1'b1, 1'b0, 32'h300, 32'h400);
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp_q[0]) begin
      n_fail++;
      $display("FAIL rst_drain_redirect: rv=%b pc=%h required 1 pc=%h",
               redirect_valid, redirect_pc, exp_q[0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    n_checks++;
    if ({redirect_valid, flush, busy, state_dbg} !== 5'b01110) begin
      n_fail++;
      $display("FAIL rst_drain_in_drain: rv/flush/busy/state=%b required 01110",
               {redirect_valid, flush, busy, state_dbg});
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({redirect_valid, flush, busy, br_ready} !== 4'b0001 || redirect_pc !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_drain_async: rv/flush/busy/ready=%b pc=%h required 0001 pc=00000000",
               {redirect_valid, flush, busy, br_ready}, redirect_pc);
    end
    redirect_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({redirect_valid, flush, busy, br_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_drain_after: rv/flush/busy/ready=%b required 0001",
               {redirect_valid, flush, busy, br_ready});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] jp [4];
    int flush_seen;
    jp[0] = 2'b11; jp[1] = 2'b00; jp[2] = 2'b11; jp[3] = 2'b00;
    flush_seen = 0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (br_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready[%0d]: br_ready=%b required 1", i, br_ready);
      end
      br_valid  = 1'b1;
      br_jump   = jp[i][1];
      br_pred   = jp[i][0];
      br_pc     = 32'h1000 + 32'(i * 16);
      br_target = 32'h2000 + 32'(i * 16);
      @(negedge clk);
      if (flush || redirect_valid) flush_seen++;
    end
    br_valid = 1'b0;
    @(negedge clk);
    if (flush || redirect_valid) flush_seen++;
    n_checks++;
    if (flush_seen != 0) begin
      n_fail++;
      $display("FAIL b2b_no_flush: flush/redirect cycles=%0d required 0", flush_seen);
    end
`ifdef BRANCH_STATS_EN
    n_checks++;
    if (stat_branches !== 32'd4 || stat_mispred !== 32'd0) begin
      n_fail++;
      $display("FAIL b2b_stats: branches=%0d mispred=%0d required 4/0", stat_branches, stat_mispred);
    end
`endif
    // One further mispredict, not taken, so the fall-through PC is used.
    redirect_ready = 1'b1;
    exp_q.push_back(32'h504);
    drive_branch(1'b0, 1'b1, 32'h500, 32'h9000);
    n_checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== exp_q[0]) begin
      n_fail++;
      $display("FAIL b2b_mp_pc: rv=%b pc=%h required 1 pc=%h", redirect_valid, redirect_pc, exp_q[0]);
    end
    void'(exp_q.pop_front());
`ifdef BRANCH_STATS_EN
    n_checks++;
    if (stat_branches !== 32'd5 || stat_mispred !== 32'd1) begin
      n_fail++;
      $display("FAIL b2b_stats_mp: branches=%0d mispred=%0d required 5/1", stat_branches, stat_mispred);
    end
`endif
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    n_checks++;
    if (busy !== 1'b0 || flush !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_return_idle: busy=%b flush=%b required 0/0", busy, flush);
    end
    redirect_ready = 1'b0;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    apply_reset();
    test_reset();
    test_correct_pred();
    test_mispredict_taken();
    test_mispredict_wrap_stall();
    test_reset_in_drain();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_redirect.md
Name: branch_redirect

Overview:
- Consumer of the branch decision produced in execute: the integer compare, or the float compare used for fbeq/fbne/fblt/fbge.
- Compares the resolved outcome with the prediction made at fetch; on mismatch, drives the PC redirect handshake into fetch and flushes the younger pipeline stages.
- Sits between the execute stage and the fetch/PC unit.
- Correctly predicted branches pass through with no bubble.

Parameters:
- DRAIN_CYCLES, 2: extra cycles `flush` stays asserted after the redirect handshake completes (0 allowed).
- CNT_W, 32: width of the statistics counters (optional feature only).

Ports:
- clk  input  1  clock, rising edge
- rstn  input  1  asynchronous active-low reset
- br_valid  input  1  execute presents a resolved branch
- br_ready  output  1  unit can accept a branch
- br_jump  input  1  resolved outcome (1 = taken)
- br_pred  input  1  prediction made at fetch (1 = taken)
- br_pc  input  32  PC of the branch instruction
- br_target  input  32  taken target
- redirect_valid  output  1  corrected PC offered to fetch
- redirect_ready  input  1  fetch accepts the redirect
- redirect_pc  output  32  corrected PC
- flush  output  1  kill all instructions younger than the branch
- busy  output  1  state != IDLE

Behaviour:
- Reset (asynchronous, rstn=0): state=IDLE, redirect_valid=0, redirect_pc=0, flush=0, drain counter=0, busy=0. Outputs clear immediately, including mid-redirect; any pending redirect is dropped.
- br_ready = (state==IDLE). This is combinational from state only, never from br_valid.
- Accept = br_valid & br_ready on a rising edge. Inputs are sampled only at accept; they are don't-care otherwise.
- mispredict = br_jump ^ br_pred.
- Correct PC = br_jump ? br_target : br_pc + 4. Addition is mod 2^32, so 0xFFFFFFFC + 4 = 0.
- States:
  - IDLE:
    - Accept with mispredict → REDIRECT. Register redirect_pc = correct PC.
    - Accept without mispredict → stay IDLE. No output change; the next branch may be accepted in the very next cycle.
  - REDIRECT:
    - redirect_valid=1, flush=1.
    - redirect_pc is stable until the handshake.
    - On redirect_valid & redirect_ready: → DRAIN (load counter = DRAIN_CYCLES-1) if DRAIN_CYCLES>0, else → IDLE.
  - DRAIN:
    - flush=1, redirect_valid=0.
    - Counter decrements each cycle; at 0 → IDLE.
- Latency:
  - Accept at edge T gives redirect_valid and flush high from cycle T+1.
  - If redirect_ready is held high, the handshake completes in cycle T+1.
  - flush then stays high for DRAIN_CYCLES more cycles, so total flush = 1 + wait + DRAIN_CYCLES cycles.
- Simultaneous events:
  - br_valid while not IDLE is not accepted; execute must hold its inputs.
  - redirect_ready while redirect_valid=0 is ignored.
- flush is registered and glitch-free. It is never asserted in IDLE.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds output ports
  - stat_branches [CNT_W-1:0], incremented on every accept;
  - stat_mispred [CNT_W-1:0], incremented on every mispredicting accept.
- Counter behaviour when defined:
  - Both counters reset to 0 and wrap modulo 2^CNT_W.
  - Both update on the accept edge, so an accept at edge T is visible from cycle T+1.
- Not defined: these ports and counters do not exist. Core behaviour is identical.

Test Plan:
- Reset, then br_valid=1, br_jump=1, br_pred=1, br_pc=0x100, br_target=0x200 → stays IDLE, redirect_valid=0, flush=0, br_ready=1 the next cycle.
- br_jump=1, br_pred=0, br_target=0x200, redirect_ready=1 → T+1: redirect_valid=1, redirect_pc=0x200, flush=1. flush is then high for 1+2 cycles total (DRAIN_CYCLES=2), then IDLE.
- br_jump=0, br_pred=1, br_pc=0xFFFFFFFC, redirect_ready held 0 for 3 cycles → redirect_pc=0x00000000 held stable while redirect_valid=1. br_ready=0 throughout, and a second br_valid presented meanwhile is not accepted.
- Reset asserted during the DRAIN of a mispredict → flush, redirect_valid and busy drop immediately. After rstn release: IDLE, br_ready=1.
- Back-to-back correct branches on 4 consecutive cycles → all 4 accepted, zero flush cycles. With BRANCH_STATS_EN: stat_branches=4, stat_mispred=0; after one further mispredict: 5 and 1.
